svreal_mul_sched: RTL and testbench



---
 rtl/svreal_sched_pkg.sv | 44 ++++
 rtl/svreal_rr_arbiter.sv | 45 ++++
 rtl/svreal_mul_sched.sv | 144 ++++++++++++++
 tb/tb_svreal_mul_sched.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/svreal_sched_pkg.sv
// Shared helpers for the time-multiplexed svreal multiplier scheduler:
// ID sizing, exponent alignment and signed saturation of wide products.
package svreal_sched_pkg;

    // Working width for the aligned product before clamping; must hold
    // A_W+B_W bits plus any left shift required by the exponents.
    localparam int WIDE_W = 64;

    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int prod_width(input int a_w, input int b_w);
        return a_w + b_w;
    endfunction

    // Positive result means the product must be shifted left into C format.
    function automatic int align_shift(input int a_exp, input int b_exp, input int c_exp);
        return (a_exp + b_exp) - c_exp;
    endfunction

    // Clamp v into the signed range of a c_w-bit value and flag clipping.
    function automatic logic signed [WIDE_W-1:0] sat_clamp(
        input  logic signed [WIDE_W-1:0] v,
        input  int                       c_w,
        output logic                     sat
    );
        logic signed [WIDE_W-1:0] hi;
        logic signed [WIDE_W-1:0] lo;
        hi = (64'sd1 <<< (c_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (c_w - 1));
        sat = 1'b0;
        if (v > hi) begin
            sat = 1'b1;
            return hi;
        end
        if (v < lo) begin
            sat = 1'b1;
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/svreal_rr_arbiter.sv
// Round-robin arbiter: grants the first active request at or above the
// pointer (with wrap) and moves the pointer just past each winner.
module svreal_rr_arbiter
    import svreal_sched_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int ID_W = id_width(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] gnt_id
);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] idx;
    logic            found;

    // Search upward from ptr with wrap-around; first active request wins.
    always_comb begin
        grant  = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = ptr;
        for (int i = 0; i < NREQ; i++) begin
            idx = ID_W'((int'(ptr) + i) % NREQ);
            if (en && !found && req[idx]) begin
                grant[idx] = 1'b1;
                gnt_id     = idx;
                found      = 1'b1;
            end
        end
    end

    // Pointer moves past the winner only when a grant is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (found)
            ptr <= (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;
    end

endmodule

// File: rtl/svreal_mul_sched.sv
// Shares one pipelined signed multiplier between NREQ requesters. Products
// are realigned from the A*B exponent to the C format, saturated, and
// returned tagged with the requester index. The whole pipe stalls together
// when the result register is full and the consumer is not ready.
module svreal_mul_sched
    import svreal_sched_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int A_W   = 16,
    parameter  int A_EXP = -8,
    parameter  int B_W   = 17,
    parameter  int B_EXP = -9,
    parameter  int C_W   = 18,
    parameter  int C_EXP = -10,
    parameter  int PIPE  = 2,
    localparam int ID_W  = id_width(NREQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ-1:0][A_W-1:0]   req_a,
    input  logic [NREQ-1:0][B_W-1:0]   req_b,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [ID_W-1:0]            res_id,
    output logic signed [C_W-1:0]      res_value,
    output logic                       res_sat,
    output logic [15:0]                sat_count
);

    localparam int PROD_W = prod_width(A_W, B_W);
    localparam int SH     = align_shift(A_EXP, B_EXP, C_EXP);

    logic            adv;
    logic            accept;
    logic [ID_W-1:0] gnt_id;

    assign adv = !res_valid || res_ready;

    // Grants are suppressed during reset so nothing appears accepted.
    svreal_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_valid),
        .en     (adv && rst_n),
        .grant  (req_ready),
        .gnt_id (gnt_id)
    );

    assign accept = |(req_valid & req_ready);

    logic                    vld_p0;
    logic [ID_W-1:0]         id_p0;
    logic signed [A_W-1:0]   a_p0;
    logic signed [B_W-1:0]   b_p0;

    logic [PIPE:1]           vld_pk;
    logic [ID_W-1:0]         id_pk   [1:PIPE];
    logic signed [PROD_W-1:0] prod_pk [1:PIPE];

    // Operand stage valid: a bubble enters whenever nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_p0 <= 1'b0;
        else if (adv)
            vld_p0 <= accept;
    end

    // Operand stage data: capture the winner's operands and index.
    always_ff @(posedge clk) begin
        if (adv && accept) begin
            id_p0 <= gnt_id;
            a_p0  <= $signed(req_a[gnt_id]);
            b_p0  <= $signed(req_b[gnt_id]);
        end
    end

    // Multiplier stage valids shift in lockstep with the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pk <= '0;
        end else if (adv) begin
            vld_pk[1] <= vld_p0;
            for (int k = 2; k <= PIPE; k++)
                vld_pk[k] <= vld_pk[k-1];
        end
    end

    // Multiply on entry, then carry the full-precision product down the pipe.
    always_ff @(posedge clk) begin
        if (adv) begin
            prod_pk[1] <= a_p0 * b_p0;
            id_pk[1]   <= id_p0;
            for (int k = 2; k <= PIPE; k++) begin
                prod_pk[k] <= prod_pk[k-1];
                id_pk[k]   <= id_pk[k-1];
            end
        end
    end

    logic signed [WIDE_W-1:0] ext_w;
    logic signed [WIDE_W-1:0] aligned_w;
    logic signed [WIDE_W-1:0] clamped_w;
    logic                     sat_w;

    // Realign to the C exponent (right shift floors) and clamp to C_W bits.
    always_comb begin
        ext_w = WIDE_W'(prod_pk[PIPE]);
        if (SH < 0)
            aligned_w = ext_w >>> (-SH);
        else if (SH > 0)
            aligned_w = ext_w <<< SH;
        else
            aligned_w = ext_w;
        clamped_w = sat_clamp(aligned_w, C_W, sat_w);
    end

    // Result register: loads only when the pipe advances, else holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_id    <= '0;
            res_value <= '0;
            res_sat   <= 1'b0;
        end else if (adv) begin
            res_valid <= vld_pk[PIPE];
            if (vld_pk[PIPE]) begin
                res_id    <= id_pk[PIPE];
                res_value <= C_W'(clamped_w);
                res_sat   <= sat_w;
            end
        end
    end

    // Count delivered saturated results, sticking at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_count <= '0;
        else if (res_valid && res_ready && res_sat && (sat_count != 16'hFFFF))
            sat_count <= sat_count + 16'd1;
    end

endmodule

// File: tb/tb_svreal_mul_sched.sv
// Directed bench for svreal_mul_sched with hand-computed expected values.
`timescale 1ns/1ps
module tb_svreal_mul_sched;

    localparam int NREQ = 4;
    localparam int A_W  = 16;
    localparam int B_W  = 17;
    localparam int C_W  = 18;
    localparam int ID_W = 2;
    localparam int PIPE = 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ-1:0][A_W-1:0] req_a;
    logic [NREQ-1:0][B_W-1:0] req_b;
    logic                     res_valid;
    logic                     res_ready;
    logic [ID_W-1:0]          res_id;
    logic signed [C_W-1:0]    res_value;
    logic                     res_sat;
    logic [15:0]              sat_count;

    int n_assert = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;
    int exp_q[$];

    always #5 clk = ~clk;

    svreal_mul_sched #(
        .NREQ(NREQ), .A_W(A_W), .A_EXP(-8), .B_W(B_W), .B_EXP(-9),
        .C_W(C_W), .C_EXP(-10), .PIPE(PIPE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_value (res_value),
        .res_sat   (res_sat),
        .sat_count (sat_count)
    );

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Stream scoreboard: requester k carries a=0.5*(k+1), b=1.0, so the
    // C-format result is 512*(k+1). Results must follow acceptance order.
    always @(negedge clk) begin
        int id;
        if (mon_en && rst_n) begin
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("stream_extra", 1, 0);
                end else begin
                    id = exp_q.pop_front();
                    check_eq("stream_id", res_id, id);
                    check_eq("stream_val", res_value, 512 * (id + 1));
                end
            end
            for (int k = 0; k < NREQ; k++)
                if (req_valid[k] && req_ready[k])
                    exp_q.push_back(k);
        end
    end

    task automatic run_op(input int k, input int a, input int b,
                          input int ev, input int es, input string tag);
        req_a[k]  = A_W'(a);
        req_b[k]  = B_W'(b);
        req_valid = NREQ'(1 << k);
        #1;
        check_eq({tag, "_ready"}, req_ready, 1 << k);
        @(posedge clk); #1;
        req_valid = '0;
        check_eq({tag, "_lat0"}, res_valid, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq({tag, "_lat2"}, res_valid, 0);
        @(posedge clk); #1;
        check_eq({tag, "_valid"}, res_valid, 1);
        check_eq({tag, "_id"}, res_id, k);
        check_eq({tag, "_value"}, res_value, ev);
        check_eq({tag, "_sat"}, res_sat, es);
        @(posedge clk); #1;
        check_eq({tag, "_done"}, res_valid, 0);
    endtask

    task automatic drain(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (!res_valid && exp_q.size() == 0) done = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check_eq({tag, "_drained"}, done, 1);
        check_eq({tag, "_qempty"}, exp_q.size(), 0);
        check_eq({tag, "_idle"}, res_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '1;
        res_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", res_valid, 0);
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_value", res_value, 0);
        check_eq("rst_id", res_id, 0);
        check_eq("rst_sat", res_sat, 0);
        check_eq("rst_satcnt", sat_count, 0);
        req_valid = '0;
        rst_n     = 1'b1;
        @(posedge clk); #1;

        run_op(0, 384, 1024, 3072, 0, "basic");
        check_eq("basic_satcnt", sat_count, 0);
        run_op(1, -128, 3072, -3072, 0, "neg");
        run_op(2, 1, 1, 0, 0, "tiny");
        run_op(3, -1, 1, -1, 0, "floor");
        run_op(1, 25600, 51200, 131071, 1, "satp");
        check_eq("satp_satcnt", sat_count, 1);
        run_op(3, -25600, 51200, -131072, 1, "satn");
        check_eq("satn_satcnt", sat_count, 2);

        // Round-robin: pointer is back at 0 after the last grant went to 3.
        for (int k = 0; k < NREQ; k++) begin
            req_a[k] = A_W'(128 * (k + 1));
            req_b[k] = B_W'(512);
        end
        mon_en    = 1'b1;
        req_valid = '1;
        for (int i = 0; i < 7; i++) begin
            #1;
            check_eq("rr_grant", req_ready, 1 << (i % 4));
            @(posedge clk); #1;
        end
        req_valid = 4'b0101;
        #1;
        check_eq("rr_wrap0", req_ready, 4'b0001);
        @(posedge clk); #1; #1;
        check_eq("rr_then2", req_ready, 4'b0100);
        @(posedge clk); #1;
        req_valid = '0;
        drain("rr");

        // Backpressure on a continuous stream.
        req_valid = '1;
        repeat (4) begin @(posedge clk); #1; end
        res_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_ready", req_ready, 0);
            check_eq("bp_valid", res_valid, 1);
            check_eq("bp_id", res_id, exp_q[0]);
            check_eq("bp_value", res_value, 512 * (exp_q[0] + 1));
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        req_valid = '0;
        drain("bp");

        // Reset with products in flight and one result presented.
        mon_en    = 1'b0;
        req_a[0]  = A_W'(25600);
        req_b[0]  = B_W'(51200);
        req_valid = 4'b0001;
        repeat (3) begin @(posedge clk); #1; end
        req_valid = '0;
        @(posedge clk); #1;
        check_eq("mid_valid_pre", res_valid, 1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_valid_drop", res_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < PIPE + 2; i++) begin
            @(posedge clk); #1;
            check_eq("mid_no_result", res_valid, 0);
        end
        check_eq("mid_satcnt", sat_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
